change_calculator: RTL and testbench

- Registered change/validity calculator for the vending-machine datapath.
- On a `calculate` strobe it compares the inserted amount against the selected product price.
- It latches the change to return and a transaction-valid flag, plus the greedy coin breakdown of that change.
- It then sequences the change out one coin per cycle for the coin-return mechanism.

---
 rtl/change_calculator.sv | 115 +++++++++++
 tb/tb_change_calculator.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/change_calculator.sv
// change_calculator: latches change/validity and its greedy 10/5/1 coin
// breakdown on a calculate strobe, then dispenses that change one coin per cycle.
`default_nettype none

module change_calculator #(
  parameter int AMOUNT_W = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [AMOUNT_W-1:0] current_amount,
  input  logic [AMOUNT_W-1:0] product_price,
  input  logic                calculate,
  output logic [AMOUNT_W-1:0] change_amount,
  output logic                valid_transaction,
  output logic                insufficient_funds,
  output logic                cancelled,
  output logic                result_ready,
  output logic [1:0]          coin10_count,
  output logic                coin5_count,
  output logic [2:0]          coin1_count,
  output logic                coin_valid,
  output logic [AMOUNT_W-1:0] coin_value,
  output logic                dispense_done
);

  localparam logic [AMOUNT_W-1:0] C_TEN  = AMOUNT_W'(10);
  localparam logic [AMOUNT_W-1:0] C_FIVE = AMOUNT_W'(5);
  localparam logic [AMOUNT_W-1:0] C_ONE  = AMOUNT_W'(1);

  typedef enum logic {IDLE = 1'b0, DISPENSE = 1'b1} state_t;

  state_t              state;
  logic [AMOUNT_W-1:0] remaining;

  logic                new_valid;
  logic [AMOUNT_W-1:0] new_change;
  logic [AMOUNT_W-1:0] q10;
  logic [AMOUNT_W-1:0] q5;
  logic [AMOUNT_W-1:0] q1;
  logic [AMOUNT_W-1:0] denom;
  logic                unused_quotient_bits;

  always_comb begin
    new_valid  = (product_price != '0) && (current_amount >= product_price);
    new_change = new_valid ? (current_amount - product_price) : current_amount;
    q10        = new_change / C_TEN;
    q5         = (new_change % C_TEN) / C_FIVE;
    q1         = new_change % C_FIVE;
  end

  // Upper quotient bits are zero for the 5-bit money range.
  assign unused_quotient_bits = ^{q10[AMOUNT_W-1:2], q5[AMOUNT_W-1:1], q1[AMOUNT_W-1:3]};

  always_comb begin
    denom = C_ONE;
    if (remaining >= C_TEN) begin
      denom = C_TEN;
    end else if (remaining >= C_FIVE) begin
      denom = C_FIVE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state              <= IDLE;
      remaining          <= '0;
      change_amount      <= '0;
      valid_transaction  <= 1'b0;
      insufficient_funds <= 1'b0;
      cancelled          <= 1'b0;
      result_ready       <= 1'b0;
      coin10_count       <= '0;
      coin5_count        <= 1'b0;
      coin1_count        <= '0;
      coin_valid         <= 1'b0;
      coin_value         <= '0;
      dispense_done      <= 1'b0;
    end else begin
      result_ready  <= 1'b0;
      coin_valid    <= 1'b0;
      coin_value    <= '0;
      dispense_done <= 1'b0;
      if (calculate) begin
        // A new request always wins, abandoning any coins still owed.
        change_amount      <= new_change;
        valid_transaction  <= new_valid;
        insufficient_funds <= (product_price != '0) && (current_amount < product_price);
        cancelled          <= (product_price == '0);
        coin10_count       <= q10[1:0];
        coin5_count        <= q5[0];
        coin1_count        <= q1[2:0];
        result_ready       <= 1'b1;
        remaining          <= new_change;
        if (new_change != '0) begin
          state <= DISPENSE;
        end else begin
          state         <= IDLE;
          dispense_done <= 1'b1;
        end
      end else if (state == DISPENSE) begin
        if (remaining == '0) begin
          dispense_done <= 1'b1;
          state         <= IDLE;
        end else begin
          coin_valid <= 1'b1;
          coin_value <= denom;
          remaining  <= remaining - denom;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_change_calculator.sv
// Directed, table-driven bench for change_calculator.
`default_nettype none

module tb_change_calculator;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] current_amount;
  logic [4:0] product_price;
  logic       calculate;
  logic [4:0] change_amount;
  logic       valid_transaction;
  logic       insufficient_funds;
  logic       cancelled;
  logic       result_ready;
  logic [1:0] coin10_count;
  logic       coin5_count;
  logic [2:0] coin1_count;
  logic       coin_valid;
  logic [4:0] coin_value;
  logic       dispense_done;

  int vectors     = 0;
  int miscompares = 0;

  change_calculator #(.AMOUNT_W(5)) dut (
    .clk(clk), .reset(reset),
    .current_amount(current_amount), .product_price(product_price),
    .calculate(calculate),
    .change_amount(change_amount), .valid_transaction(valid_transaction),
    .insufficient_funds(insufficient_funds), .cancelled(cancelled),
    .result_ready(result_ready),
    .coin10_count(coin10_count), .coin5_count(coin5_count), .coin1_count(coin1_count),
    .coin_valid(coin_valid), .coin_value(coin_value), .dispense_done(dispense_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] amt;
    logic [4:0] price;
    logic [4:0] change;
    logic       valid;
    logic       insuf;
    logic       canc;
    logic [1:0] c10;
    logic       c5;
    logic [2:0] c1;
  } vec_t;

  vec_t tbl [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [21:0] all_outs();
    return {change_amount, valid_transaction, insufficient_funds, cancelled, result_ready,
            coin10_count, coin5_count, coin1_count, coin_valid, coin_value, dispense_done};
  endfunction

  // Strobe calculate for one edge; returns at the negedge where results are visible.
  task automatic start_calc(input logic [4:0] a, input logic [4:0] p);
    @(negedge clk);
    current_amount = a;
    product_price  = p;
    calculate      = 1'b1;
    @(negedge clk);
    calculate = 1'b0;
  endtask

  int n10, n5, n1, nbad, ncoins;
  logic got_done;
  logic [4:0] prev;

  // Tally coins from the current negedge until dispense_done or a cycle budget.
  task automatic collect();
    n10 = 0; n5 = 0; n1 = 0; nbad = 0; ncoins = 0; got_done = 1'b0; prev = 5'd31;
    for (int c = 0; c < 20; c++) begin
      if (coin_valid) begin
        ncoins++;
        if (coin_value == 5'd10) n10++;
        else if (coin_value == 5'd5) n5++;
        else if (coin_value == 5'd1) n1++;
        else nbad++;
        if (coin_value > prev) nbad++;
        prev = coin_value;
      end else if (coin_value != 5'd0) begin
        nbad++;
      end
      if (dispense_done) begin
        got_done = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    //            amt    price  change v  i  c  c10   c5  c1
    tbl[0]  = '{5'd15, 5'd15, 5'd0,  1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 3'd0};
    tbl[1]  = '{5'd20, 5'd15, 5'd5,  1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 3'd0};
    tbl[2]  = '{5'd10, 5'd15, 5'd10, 1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 3'd0};
    tbl[3]  = '{5'd10, 5'd0,  5'd10, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 3'd0};
    tbl[4]  = '{5'd31, 5'd0,  5'd31, 1'b0, 1'b0, 1'b1, 2'd3, 1'b0, 3'd1};
    tbl[5]  = '{5'd29, 5'd1,  5'd28, 1'b1, 1'b0, 1'b0, 2'd2, 1'b1, 3'd3};
    tbl[6]  = '{5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 3'd0};
    tbl[7]  = '{5'd4,  5'd7,  5'd4,  1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 3'd4};
    tbl[8]  = '{5'd31, 5'd31, 5'd0,  1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 3'd0};
    tbl[9]  = '{5'd31, 5'd5,  5'd26, 1'b1, 1'b0, 1'b0, 2'd2, 1'b1, 3'd1};
    tbl[10] = '{5'd0,  5'd3,  5'd0,  1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 3'd0};

    reset = 1'b0; calculate = 1'b0; current_amount = 5'd0; product_price = 5'd0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("reset_outputs", 32'(all_outs()), 32'd0);

    for (int k = 0; k < 11; k++) begin
      start_calc(tbl[k].amt, tbl[k].price);
      check($sformatf("v%0d_result", k),
            {21'd0, change_amount, valid_transaction, insufficient_funds, cancelled},
            {21'd0, tbl[k].change, tbl[k].valid, tbl[k].insuf, tbl[k].canc});
      check($sformatf("v%0d_counts", k), {26'd0, coin10_count, coin5_count, coin1_count},
            {26'd0, tbl[k].c10, tbl[k].c5, tbl[k].c1});
      check($sformatf("v%0d_result_ready", k), 32'(result_ready), 32'd1);
      collect();
      check($sformatf("v%0d_coin_tally", k), {8'd0, 8'(n10), 8'(n5), 8'(n1)},
            {8'd0, 8'(tbl[k].c10), 8'(tbl[k].c5), 8'(tbl[k].c1)});
      check($sformatf("v%0d_coin_order", k), 32'(nbad), 32'd0);
      check($sformatf("v%0d_done_seen", k), 32'(got_done), 32'd1);
      @(negedge clk);
      check($sformatf("v%0d_hold", k),
            {11'd0, change_amount, valid_transaction, insufficient_funds, cancelled,
             result_ready, dispense_done, coin_valid, coin10_count, coin5_count, coin1_count},
            {11'd0, tbl[k].change, tbl[k].valid, tbl[k].insuf, tbl[k].canc,
             1'b0, 1'b0, 1'b0, tbl[k].c10, tbl[k].c5, tbl[k].c1});
    end

    // Abort: new calculate right after the second 10 coin of a 31 refund.
    start_calc(5'd31, 5'd0);
    ncoins = 0;
    for (int c = 0; c < 10 && ncoins < 2; c++) begin
      @(negedge clk);
      if (coin_valid) ncoins++;
    end
    check("abort_two_coins_first", 32'(ncoins), 32'd2);
    current_amount = 5'd20; product_price = 5'd15; calculate = 1'b1;
    @(negedge clk);
    calculate = 1'b0;
    check("abort_new_result", {26'd0, change_amount, result_ready}, {26'd0, 5'd5, 1'b1});
    check("abort_no_old_coin", 32'(coin_valid), 32'd0);
    collect();
    check("abort_single_five", {8'd0, 8'(n10), 8'(n5), 8'(n1)}, {8'd0, 8'd0, 8'd1, 8'd0});
    check("abort_done", 32'(got_done), 32'd1);

    // Reset mid-dispense: everything clears, no dispense_done afterwards.
    start_calc(5'd31, 5'd0);
    @(negedge clk);
    check("mid_coin_before_reset", {27'd0, coin_valid, coin_value[3:0]}, {27'd0, 1'b1, 4'd10});
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("mid_reset_outputs", 32'(all_outs()), 32'd0);
    ncoins = 0; got_done = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (coin_valid) ncoins++;
      if (dispense_done) got_done = 1'b1;
    end
    check("post_reset_quiet", {31'd0, got_done} + 32'(ncoins), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
